ifetch_stage: RTL and testbench
===============================

# ifetch_stage

Instruction-fetch stage directly upstream of the decode stage. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Registers the returned word into an instruction register that drives decode's `Instr` input. Advances the PC sequentially (PC+4) or to a branch target (PC+4+Immed), using the already sign-extended, shifted `Immed` that decode produces.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded by reset. Bits [1:0] are forced to 0.

Ports:
- `Clk` in 1: single clock; all state updates on its rising edge.
- `Reset_n` in 1: reset is asynchronous and active-low.
- `PC_Immed` in 32: branch offset from decode `Immed`, already sign-extended and shifted left by 2.
- `PC_sel` in 1: 0 selects PC+4; 1 selects PC+4+PC_Immed.
- `PC_LdEn` in 1: control permission to advance the PC; 0 stalls the stage.
- `Imem_Req` out 1: read request to instruction memory.
- `Imem_Addr` out 32: word address of the read, equal to PC.
- `Imem_Ack` in 1: memory returns data this cycle.
- `Imem_Data` in 32: instruction word, valid while `Imem_Ack`=1.
- `Instr` out 32: instruction register, fed to decode.
- `Instr_Valid` out 1: `Instr` holds a fetched, unconsumed instruction.
- `Instr_Ready` in 1: decode consumes `Instr` this cycle.
- `PC` out 32: address of the instruction in `Instr`, or of the fetch in flight.

## Operation
- FSM states:
  - BOOT: entered on reset; lasts exactly 1 cycle, then goes to FETCH.
  - FETCH: `Imem_Req`=1 and `Imem_Addr`=PC. On `Imem_Ack`, load `Instr` from `Imem_Data` and go to HOLD. Otherwise stay in FETCH.
  - HOLD: `Instr_Valid`=1. When `Instr_Ready` and `PC_LdEn` are both 1 in the same cycle ("consume"), load the next PC and go to FETCH. Otherwise stay in HOLD with `Instr` and PC unchanged.
- Next PC is computed only on consume:
  - Next PC = PC + 4 + (PC_sel ? PC_Immed : 0).
  - Arithmetic is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal and silent.
  - Bits [1:0] of the result are forced to 0.
- `PC_sel` and `PC_Immed` are sampled only in the consume cycle.
- Handshake rules:
  - `Imem_Req` and `Imem_Addr` stay stable from assertion until `Imem_Ack`.
  - `Imem_Ack` outside FETCH is ignored and has no state effect.
- Stalls:
  - `Instr_Ready`=1 with `PC_LdEn`=0 is a stall: no consume.
  - `PC_LdEn`=1 with `Instr_Ready`=0 is also no consume.
- `Instr` changes only on an accepted `Imem_Ack`.
- Reset values, asynchronous on `Reset_n`=0:
  - state=BOOT, PC=`RESET_PC`, `Instr`=0.
  - `Instr_Valid`=0, `Imem_Req`=0, `Imem_Addr`=`RESET_PC`.
- Reset asserted mid-operation: any in-flight request is abandoned at once and `Imem_Req` drops asynchronously. Memory must tolerate a dropped request; a late `Imem_Ack` lands in BOOT and is ignored.

## Timing
- Zero-wait memory (ack in the request cycle):
  - Request in cycle N; `Instr_Valid`=1 in cycle N+1.
  - Consume in N+1; next request in N+2.
  - Throughput is 1 instruction per 2 cycles.
- Each wait cycle of memory adds 1 cycle of latency.
- After reset release, the first `Imem_Req` asserts on the 2nd rising edge (BOOT takes 1 cycle).
- `Instr_Valid` and `Imem_Req` are decoded from state and are never 1 simultaneously.
- PC updates on the clock edge that ends the consume cycle.

## Configuration
- `IFETCH_PERF_CNT_EN`:
  - Defined: adds output `Fetch_Count` (32 bits). It resets to 0, increments by 1 on every consume, and wraps at 2^32.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `ifetch_pkg` holds:
  - state enum (BOOT, FETCH, HOLD);
  - constant `INSTR_BYTES`=4;
  - default reset-vector constant.
- One sub-module, `ifetch_pc_reg`, contains the PC register, the next-PC adder/mux and the alignment masking. The FSM and instruction register live in the top module.

## Test plan
- Reset and boot: release reset with `RESET_PC`=32'h100 and zero-wait ack -> `Imem_Req` rises on the 2nd edge with `Imem_Addr`=32'h100; next cycle `Instr_Valid`=1 and `Instr`=`Imem_Data`.
- Sequential run: always-ready decode, `PC_sel`=0, 4 instructions -> `Imem_Addr` sequence is 100, 104, 108, 10C, one request every 2 cycles.
- Branch: PC=32'h200, `PC_sel`=1, `PC_Immed`=32'hFFFF_FFF0 on consume -> next `Imem_Addr`=32'h1F4. With `PC_Immed`=32'h0000_0021 -> 32'h224, low bits masked.
- Stall and wait states:
  - 3-cycle `Imem_Ack` delay -> `Imem_Addr` is stable and `Instr_Valid`=0 throughout.
  - `PC_LdEn`=0 for 5 cycles in HOLD -> PC and `Instr` are unchanged.
  - Stray `Imem_Ack` in HOLD -> ignored.
- Reset mid-fetch and wrap:
  - Assert `Reset_n`=0 while `Imem_Req`=1 -> all outputs reach their reset values immediately.
  - PC=32'hFFFF_FFFC, sequential consume -> next PC is 0.
- Counter, with `IFETCH_PERF_CNT_EN` defined: 7 consumes -> `Fetch_Count`=7. Reset -> 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: IFETCH_PERF_CNT_EN (consume counter).
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        ld_en;
    logic        sel;
    logic [31:0] immed;
  } pc_ctl_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter register with sequential/branch next-PC selection.
// Loads only when ld_en is asserted; result is always word aligned.
module ifetch_pc_reg
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_ctl_t     ctl,
  output logic [31:0] pc
);

  localparam logic [31:0] RST_PC = align_pc(RESET_PC);

  logic [31:0] seq_pc;
  logic [31:0] offset;
  logic [31:0] next_pc;

  always_comb begin
    seq_pc  = pc + 32'(INSTR_BYTES);
    offset  = ctl.sel ? ctl.immed : 32'h0;
    next_pc = align_pc(seq_pc + offset);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RST_PC;
    end else if (ctl.ld_en) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC, imem req/ack handshake and instruction register.
// Define IFETCH_PERF_CNT_EN to add the Fetch_Count consume counter.
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] PC_Immed,
  input  logic        PC_sel,
  input  logic        PC_LdEn,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] PC
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] Fetch_Count
`endif
);

  fetch_state_t state;
  logic         boot_arm;
  logic         consume;
  pc_ctl_t      pc_ctl;

  assign consume = (state == HOLD) & Instr_Ready & PC_LdEn;

  always_comb begin
    pc_ctl.ld_en = consume;
    pc_ctl.sel   = PC_sel;
    pc_ctl.immed = PC_Immed;
  end

  ifetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (Clk),
    .rst_n (Reset_n),
    .ctl   (pc_ctl),
    .pc    (PC)
  );

  assign Imem_Addr = PC;

  // BOOT spans the first full cycle after release; boot_arm marks it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= BOOT;
      boot_arm    <= 1'b0;
      Instr       <= 32'h0;
      Imem_Req    <= 1'b0;
      Instr_Valid <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          if (boot_arm) begin
            state    <= FETCH;
            Imem_Req <= 1'b1;
          end else begin
            boot_arm <= 1'b1;
          end
        end
        FETCH: begin
          if (Imem_Ack) begin
            Instr       <= Imem_Data;
            state       <= HOLD;
            Imem_Req    <= 1'b0;
            Instr_Valid <= 1'b1;
          end
        end
        HOLD: begin
          if (consume) begin
            state       <= FETCH;
            Imem_Req    <= 1'b1;
            Instr_Valid <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          Imem_Req    <= 1'b0;
          Instr_Valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Fetch_Count <= 32'h0;
    end else if (consume) begin
      Fetch_Count <= Fetch_Count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: vector table plus corner sequences.
// Honours IFETCH_PERF_CNT_EN to check Fetch_Count when built with it.
module tb_ifetch_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] PC_Immed;
  logic        PC_sel;
  logic        PC_LdEn;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] PC;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] Fetch_Count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;

  always #5 Clk = ~Clk;

  ifetch_stage #(
    .RESET_PC (32'h0000_0100)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .PC_Immed    (PC_Immed),
    .PC_sel      (PC_sel),
    .PC_LdEn     (PC_LdEn),
    .Imem_Req    (Imem_Req),
    .Imem_Addr   (Imem_Addr),
    .Imem_Ack    (Imem_Ack),
    .Imem_Data   (Imem_Data),
    .Instr       (Instr),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready),
    .PC          (PC)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .Fetch_Count (Fetch_Count)
`endif
  );

  typedef struct {
    logic [31:0] exp_addr;
    logic [31:0] data;
    logic        sel;
    logic [31:0] immed;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for a request, then acks it.
  task automatic do_fetch(input logic [31:0] exp_addr,
                          input logic [31:0] data,
                          input string tag);
    int n = 0;
    while (!Imem_Req && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_req"}, 32'(Imem_Req), 32'h1);
    chk({tag, "_addr"}, Imem_Addr, exp_addr);
    chk({tag, "_vld0"}, 32'(Instr_Valid), 32'h0);
    Imem_Ack  = 1'b1;
    Imem_Data = data;
    @(negedge Clk);
    Imem_Ack  = 1'b0;
    Imem_Data = 32'h0;
    chk({tag, "_vld1"}, 32'(Instr_Valid), 32'h1);
    chk({tag, "_instr"}, Instr, data);
    chk({tag, "_pc"}, PC, exp_addr);
    chk({tag, "_req0"}, 32'(Imem_Req), 32'h0);
  endtask

  task automatic do_consume(input logic sel, input logic [31:0] immed,
                            input logic [31:0] exp_next,
                            input string tag);
    Instr_Ready = 1'b1;
    PC_LdEn     = 1'b1;
    PC_sel      = sel;
    PC_Immed    = immed;
    @(negedge Clk);
    Instr_Ready = 1'b0;
    PC_LdEn     = 1'b0;
    PC_sel      = 1'b0;
    PC_Immed    = 32'h0;
    model_cnt++;
    chk({tag, "_nreq"}, 32'(Imem_Req), 32'h1);
    chk({tag, "_nvld"}, 32'(Instr_Valid), 32'h0);
    chk({tag, "_npc"}, PC, exp_next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h0000_0100, 32'hA000_0000, 1'b0, 32'h0, 32'h0000_0104};
    vecs[1]  = '{32'h0000_0104, 32'hA000_0001, 1'b0, 32'h0, 32'h0000_0108};
    vecs[2]  = '{32'h0000_0108, 32'hA000_0002, 1'b0, 32'h0, 32'h0000_010C};
    vecs[3]  = '{32'h0000_010C, 32'hA000_0003, 1'b1, 32'h0000_00F0,
                 32'h0000_0200};
    vecs[4]  = '{32'h0000_0200, 32'hA000_0004, 1'b1, 32'hFFFF_FFF0,
                 32'h0000_01F4};
    vecs[5]  = '{32'h0000_01F4, 32'hA000_0005, 1'b1, 32'h0000_0008,
                 32'h0000_0200};
    vecs[6]  = '{32'h0000_0200, 32'hA000_0006, 1'b1, 32'h0000_0021,
                 32'h0000_0224};
    vecs[7]  = '{32'h0000_0224, 32'hA000_0007, 1'b1, 32'hFFFF_FDD4,
                 32'hFFFF_FFFC};
    vecs[8]  = '{32'hFFFF_FFFC, 32'hA000_0008, 1'b0, 32'h0, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0000, 32'hA000_0009, 1'b0, 32'h0, 32'h0000_0004};
    vecs[10] = '{32'h0000_0004, 32'hA000_000A, 1'b0, 32'h0, 32'h0000_0008};

    Reset_n     = 1'b0;
    PC_Immed    = 32'h0;
    PC_sel      = 1'b0;
    PC_LdEn     = 1'b0;
    Imem_Ack    = 1'b0;
    Imem_Data   = 32'h0;
    Instr_Ready = 1'b0;

    repeat (3) @(negedge Clk);
    chk("rst_req", 32'(Imem_Req), 32'h0);
    chk("rst_vld", 32'(Instr_Valid), 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_pc", PC, 32'h100);
    chk("rst_addr", Imem_Addr, 32'h100);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_cnt", Fetch_Count, 32'h0);
`endif
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("boot_e1_req", 32'(Imem_Req), 32'h0);
    @(negedge Clk);
    chk("boot_e2_req", 32'(Imem_Req), 32'h1);
    chk("boot_e2_addr", Imem_Addr, 32'h100);

    for (int i = 0; i < 11; i++) begin
      do_fetch(vecs[i].exp_addr, vecs[i].data, $sformatf("v%0d", i));
      do_consume(vecs[i].sel, vecs[i].immed, vecs[i].exp_next,
                 $sformatf("v%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", Imem_Addr, 32'h8);
      chk("wait_req", 32'(Imem_Req), 32'h1);
      chk("wait_vld", 32'(Instr_Valid), 32'h0);
      @(negedge Clk);
    end
    do_fetch(32'h8, 32'h1234_5678, "wait");

    for (int i = 0; i < 5; i++) begin
      Instr_Ready = 1'b1;
      PC_LdEn     = 1'b0;
      Imem_Ack    = (i == 2);
      Imem_Data   = 32'hDEAD_BEEF;
      @(negedge Clk);
      chk("stall_pc", PC, 32'h8);
      chk("stall_instr", Instr, 32'h1234_5678);
      chk("stall_vld", 32'(Instr_Valid), 32'h1);
      chk("stall_req", 32'(Imem_Req), 32'h0);
    end
    Imem_Ack    = 1'b0;
    Imem_Data   = 32'h0;
    Instr_Ready = 1'b0;
    PC_LdEn     = 1'b1;
    @(negedge Clk);
    chk("norrdy_pc", PC, 32'h8);
    chk("norrdy_vld", 32'(Instr_Valid), 32'h1);
    PC_LdEn = 1'b0;
    do_consume(1'b0, 32'h0, 32'hC, "post_stall");

`ifdef IFETCH_PERF_CNT_EN
    chk("cnt_pre", Fetch_Count, 32'(model_cnt));
`endif

    chk("mid_req_pre", 32'(Imem_Req), 32'h1);
    Reset_n   = 1'b0;
    Imem_Ack  = 1'b1;
    Imem_Data = 32'hBAD0_BAD0;
    #1;
    model_cnt = 0;
    chk("mid_req", 32'(Imem_Req), 32'h0);
    chk("mid_vld", 32'(Instr_Valid), 32'h0);
    chk("mid_instr", Instr, 32'h0);
    chk("mid_pc", PC, 32'h100);
    chk("mid_addr", Imem_Addr, 32'h100);
`ifdef IFETCH_PERF_CNT_EN
    chk("mid_cnt", Fetch_Count, 32'h0);
`endif
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("late_ack_instr", Instr, 32'h0);
    chk("late_ack_req", 32'(Imem_Req), 32'h0);
    Imem_Ack  = 1'b0;
    Imem_Data = 32'h0;
    @(negedge Clk);
    chk("reboot_req", 32'(Imem_Req), 32'h1);
    chk("reboot_addr", Imem_Addr, 32'h100);

    for (int i = 0; i < 7; i++) begin
      do_fetch(32'h100 + 32'(4 * i), 32'hC000_0000 + 32'(i), "cnt");
      do_consume(1'b0, 32'h0, 32'h104 + 32'(4 * i), "cnt");
    end
`ifdef IFETCH_PERF_CNT_EN
    chk("cnt_7", Fetch_Count, 32'h7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
